// File: rtl/speed_stats_if.sv
// Bike-computer trip-statistics bus: speed samples and buttons in, averaged/display results out.
// The master side is the upstream speed calculator plus button debouncers; the slave side is speed_stats_ctrl.
interface speed_stats_if #(
    parameter int WIDTH = 12
) ();
    logic [WIDTH-1:0] speed;
    logic             speed_valid;
    logic             clr_btn;
    logic             mode_btn;
    logic [WIDTH-1:0] max_in;
    logic [WIDTH-1:0] cur_speed;
    logic             max_r;
    logic [WIDTH-1:0] avg;
    logic             avg_valid;
    logic             busy;
    logic             overrun;
    logic [1:0]       disp_mode;
    logic [WIDTH-1:0] disp_val;

    modport master (
        output speed, speed_valid, clr_btn, mode_btn, max_in,
        input  cur_speed, max_r, avg, avg_valid, busy, overrun, disp_mode, disp_val
    );

    modport slave (
        input  speed, speed_valid, clr_btn, mode_btn, max_in,
        output cur_speed, max_r, avg, avg_valid, busy, overrun, disp_mode, disp_val
    );
endinterface

// File: rtl/speed_stats_ctrl.sv
// Trip statistics: running average via serial restoring divide; avg_valid arrives 1+SUM_W cycles after the sample.
// No stall: one pending slot absorbs a sample during a divide; any further sample is dropped and flags overrun.
module speed_stats_ctrl #(
    parameter int WIDTH       = 12,
    parameter int CNT_W       = 10,
    parameter int HOLD_CYCLES = 2000
) (
    input logic          clk,
    input logic          r,
    speed_stats_if.slave bus
);
    localparam int SUM_W  = WIDTH + CNT_W;
    localparam int STEP_W = $clog2(SUM_W);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE = 1'b0, DIV = 1'b1} state_t;

    state_t             state;
    state_t             state_nx;
    logic [SUM_W-1:0]   sum;
    logic [SUM_W-1:0]   sum_nx;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   pend_dat;
    logic               pend_vld;
    logic [SUM_W-1:0]   quo;
    logic [SUM_W-1:0]   quo_nx;
    logic [CNT_W-1:0]   rem;
    logic [CNT_W-1:0]   rem_nx;
    logic [CNT_W-1:0]   dvsr;
    logic [CNT_W:0]     trial;
    logic               q_bit;
    logic [STEP_W-1:0]  step;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               clr_fire;
    logic               take;
    logic [WIDTH-1:0]   take_dat;
    logic               start;
    logic               pend_ld;
    logic               pend_clr;
    logic               ovr_set;
    logic               div_last;

    // Fires on the HOLD_CYCLES-th consecutive high cycle; the counter then parks until release.
    assign clr_fire   = bus.clr_btn && (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
    assign bus.max_r  = r | clr_fire;
    assign bus.busy   = (state == DIV);
    assign sum_nx     = sum + SUM_W'(take_dat);

    always_comb begin
        state_nx = state;
        take     = 1'b0;
        take_dat = bus.speed;
        pend_ld  = 1'b0;
        pend_clr = 1'b0;
        ovr_set  = 1'b0;
        div_last = 1'b0;
        case (state)
            IDLE: begin
                if (pend_vld) begin
                    take     = 1'b1;
                    take_dat = pend_dat;
                    pend_clr = 1'b1;
                    pend_ld  = bus.speed_valid;
                end else if (bus.speed_valid) begin
                    take = 1'b1;
                end
            end
            DIV: begin
                div_last = (step == STEP_W'(SUM_W - 1));
                if (div_last) state_nx = IDLE;
                if (bus.speed_valid) begin
                    if (pend_vld) ovr_set = 1'b1;
                    else          pend_ld = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        // A saturated counter still consumes the sample so max tracking is unaffected.
        start = take && (cnt != CNT_MAX);
        if (start)    state_nx = DIV;
        if (clr_fire) state_nx = IDLE;
    end

    // Dividend shifts out of the top of quo while quotient bits shift in at the bottom.
    always_comb begin
        trial  = {rem, quo[SUM_W-1]};
        q_bit  = (trial >= {1'b0, dvsr});
        rem_nx = q_bit ? CNT_W'(trial - {1'b0, dvsr}) : trial[CNT_W-1:0];
        quo_nx = {quo[SUM_W-2:0], q_bit};
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state         <= IDLE;
            sum           <= '0;
            cnt           <= '0;
            pend_dat      <= '0;
            pend_vld      <= 1'b0;
            quo           <= '0;
            rem           <= '0;
            dvsr          <= '0;
            step          <= '0;
            hold_cnt      <= '0;
            bus.cur_speed <= '0;
            bus.avg       <= '0;
            bus.avg_valid <= 1'b0;
            bus.overrun   <= 1'b0;
            bus.disp_mode <= 2'd0;
            bus.disp_val  <= '0;
        end else begin
            state         <= state_nx;
            bus.avg_valid <= 1'b0;
            if (bus.speed_valid) bus.cur_speed <= bus.speed;

            if (!bus.clr_btn)                          hold_cnt <= '0;
            else if (hold_cnt != HOLD_W'(HOLD_CYCLES)) hold_cnt <= hold_cnt + 1'b1;

            if (clr_fire) begin
                sum         <= '0;
                cnt         <= '0;
                bus.avg     <= '0;
                bus.overrun <= 1'b0;
                pend_vld    <= 1'b0;
            end else begin
                if (start) begin
                    sum  <= sum_nx;
                    cnt  <= cnt + 1'b1;
                    quo  <= sum_nx;
                    rem  <= '0;
                    dvsr <= cnt + 1'b1;
                    step <= '0;
                end
                if (state == DIV) begin
                    quo  <= quo_nx;
                    rem  <= rem_nx;
                    step <= step + 1'b1;
                    if (div_last) begin
                        bus.avg       <= (|quo_nx[SUM_W-1:WIDTH]) ? '1 : quo_nx[WIDTH-1:0];
                        bus.avg_valid <= 1'b1;
                    end
                end
                if (ovr_set) bus.overrun <= 1'b1;
                if (pend_ld) begin
                    pend_vld <= 1'b1;
                    pend_dat <= bus.speed;
                end else if (pend_clr) begin
                    pend_vld <= 1'b0;
                end
            end

            if (bus.mode_btn) begin
                case (bus.disp_mode)
                    2'd1:    bus.disp_mode <= 2'd2;
                    2'd2:    bus.disp_mode <= 2'd0;
                    default: bus.disp_mode <= 2'd1;
                endcase
            end
            case (bus.disp_mode)
                2'd1:    bus.disp_val <= bus.max_in;
                2'd2:    bus.disp_val <= bus.avg;
                default: bus.disp_val <= bus.cur_speed;
            endcase
        end
    end
endmodule

// File: tb/tb_speed_stats_ctrl.sv
// Bench for speed_stats_ctrl: scoreboard of expected averages from a timestamp-based trip model,
// plus per-cycle level checks, directed scenarios and a randomized soak.
module tb_speed_stats_ctrl;
    localparam int W       = 12;
    localparam int CW      = 10;
    localparam int HOLD    = 8;
    localparam int SW      = W + CW;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int SPD_MAX = (1 << W) - 1;

    logic clk = 1'b0;
    logic r   = 1'b1;
    always #5 clk = ~clk;

    speed_stats_if #(.WIDTH(W)) bus ();
    speed_stats_if #(.WIDTH(W)) bus2 ();

    speed_stats_ctrl #(.WIDTH(W), .CNT_W(CW), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .r(r), .bus(bus)
    );
    speed_stats_ctrl #(.WIDTH(W), .CNT_W(2), .HOLD_CYCLES(HOLD)) dut_sat (
        .clk(clk), .r(r), .bus(bus2)
    );

    // External max-speed tracker attached to the main instance.
    logic [W-1:0] trk;
    always @(posedge clk) begin
        if (bus.max_r)                 trk <= '0;
        else if (bus.cur_speed > trk)  trk <= bus.cur_speed;
    end
    assign bus.max_in = trk;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
            if (nerr >= 50) begin
                $display("Result: errors=%0d of %0d checks", nerr, nchk);
                $finish;
            end
        end
    endtask

    // Reference model: tracks the trip by arithmetic and timestamps, not by FSM state.
    typedef struct packed { int val; int cyc; } exp_t;
    exp_t q[$];
    int m_sum = 0, m_cnt = 0, m_avg = 0, m_cur = 0, m_mode = 0, m_disp = 0;
    int m_hcnt = 0, m_done = 0, m_pend_dat = 0, m_div_val = 0;
    bit m_pend = 1'b0, m_ovr = 1'b0;

    task automatic model_take(input int s);
        if (m_cnt == CNT_MAX) return;
        m_sum += s;
        m_cnt++;
        m_div_val = m_sum / m_cnt;
        if (m_div_val > SPD_MAX) m_div_val = SPD_MAX;
        m_done = cyc + 1 + SW;
        q.push_back('{val: m_div_val, cyc: m_done});
    endtask

    always @(posedge clk) begin
        int tmp;
        if (r) m_disp = 0;
        else case (m_mode)
            1:       m_disp = int'(bus.max_in);
            2:       m_disp = m_avg;
            default: m_disp = m_cur;
        endcase
        if (r) begin
            m_sum = 0; m_cnt = 0; m_avg = 0; m_cur = 0; m_mode = 0;
            m_hcnt = 0; m_done = 0; m_pend = 1'b0; m_ovr = 1'b0;
            q.delete();
        end else begin
            if (bus.speed_valid) m_cur = int'(bus.speed);
            if (bus.mode_btn) m_mode = (m_mode + 1) % 3;
            m_hcnt = bus.clr_btn ? m_hcnt + 1 : 0;
            if (m_hcnt == HOLD) begin
                if (cyc < m_done) void'(q.pop_back());
                m_done = 0; m_sum = 0; m_cnt = 0; m_avg = 0; m_ovr = 1'b0; m_pend = 1'b0;
            end else if (cyc >= m_done) begin
                if (m_pend) begin
                    tmp    = m_pend_dat;
                    m_pend = bus.speed_valid;
                    if (bus.speed_valid) m_pend_dat = int'(bus.speed);
                    model_take(tmp);
                end else if (bus.speed_valid) begin
                    model_take(int'(bus.speed));
                end
            end else begin
                if (cyc + 1 == m_done) m_avg = m_div_val;
                if (bus.speed_valid) begin
                    if (m_pend) m_ovr = 1'b1;
                    else begin m_pend = 1'b1; m_pend_dat = int'(bus.speed); end
                end
            end
        end
        cyc++;
    end

    int av_cnt = 0, av2_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            chk("avg_valid on time", 0, 1);
            void'(q.pop_front());
        end
        if (bus.avg_valid) begin
            av_cnt++;
            if (q.size() == 0) chk("unexpected avg_valid", 1, 0);
            else begin
                e = q.pop_front();
                chk("avg value", bus.avg, e.val);
                chk("avg latency", cyc, e.cyc);
            end
        end
        if (bus2.avg_valid) av2_cnt++;
        chk("busy", bus.busy, (cyc < m_done) ? 1 : 0);
        chk("overrun", bus.overrun, m_ovr);
        chk("cur_speed", bus.cur_speed, m_cur);
        chk("avg level", bus.avg, m_avg);
        chk("disp_mode", bus.disp_mode, m_mode);
        chk("disp_val", bus.disp_val, m_disp);
        chk("max_r", bus.max_r, (r || (bus.clr_btn && m_hcnt == HOLD - 1)) ? 1 : 0);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int v);
        bus.speed       = W'(v);
        bus.speed_valid = 1'b1;
        tick();
        bus.speed_valid = 1'b0;
    endtask

    initial begin
        int sp_tab[3]   = '{10, 20, 30};
        int av_tab[3]   = '{10, 15, 20};
        int mode_tab[4] = '{1, 2, 0, 1};
        int dval_tab[4] = '{3000, 1500, 3000, 3000};
        int n;
        int k;
        bus.speed = '0; bus.speed_valid = 1'b0; bus.clr_btn = 1'b0; bus.mode_btn = 1'b0;
        bus2.speed = '0; bus2.speed_valid = 1'b0; bus2.clr_btn = 1'b0; bus2.mode_btn = 1'b0;
        bus2.max_in = 12'd4000;

        // Reset held for 3 cycles.
        r = 1'b1;
        tick(2);
        @(negedge clk);
        chk("reset max_r", bus.max_r, 1);
        chk("reset avg", bus.avg, 0);
        chk("reset disp_mode", bus.disp_mode, 0);
        chk("reset overrun", bus.overrun, 0);
        tick();
        r = 1'b0;
        @(negedge clk);
        chk("post-reset max_r", bus.max_r, 0);
        chk("post-reset cur_speed", bus.cur_speed, 0);
        tick();

        // Spaced samples: running average 10, 15, 20.
        for (int i = 0; i < 3; i++) begin
            pulse(sp_tab[i]);
            tick(30);
            chk("spaced avg", bus.avg, av_tab[i]);
            tick(9);
        end

        // Back-to-back: second sample pends, third is dropped.
        bus.speed = 12'd100; bus.speed_valid = 1'b1; tick();
        bus.speed = 12'd300; tick();
        bus.speed = 12'd50;  tick();
        bus.speed_valid = 1'b0;
        tick(60);
        chk("burst overrun", bus.overrun, 1);
        chk("burst avg", bus.avg, 92);

        // Clear held one cycle short of the threshold does nothing.
        bus.clr_btn = 1'b1;
        n = 0;
        for (int i = 0; i < HOLD - 1; i++) begin
            @(negedge clk); n += int'(bus.max_r); tick();
        end
        bus.clr_btn = 1'b0;
        chk("short hold pulses", n, 0);
        chk("short hold overrun", bus.overrun, 1);
        tick(2);

        // Long hold mid-divide: single clear, divide aborted.
        pulse(500);
        tick(3);
        bus.clr_btn = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); n += int'(bus.max_r); tick();
        end
        bus.clr_btn = 1'b0;
        chk("long hold pulses", n, 1);
        @(negedge clk);
        chk("clear avg", bus.avg, 0);
        chk("clear busy", bus.busy, 0);
        chk("clear overrun", bus.overrun, 0);
        k = av_cnt;
        tick(30);
        chk("avg_valid after abort", av_cnt - k, 0);

        // Fresh burst after clear: avg of first two samples.
        bus.speed = 12'd1000; bus.speed_valid = 1'b1; tick();
        bus.speed = 12'd2000; tick();
        bus.speed = 12'd3000; tick();
        bus.speed_valid = 1'b0;
        tick(60);
        chk("fresh burst avg", bus.avg, 1500);
        chk("fresh burst overrun", bus.overrun, 1);

        // Mode cycling and registered display mux.
        for (int i = 0; i < 4; i++) begin
            bus.mode_btn = 1'b1; tick();
            bus.mode_btn = 1'b0; tick();
            @(negedge clk);
            chk("mode seq", bus.disp_mode, mode_tab[i]);
            chk("mode disp_val", bus.disp_val, dval_tab[i]);
            tick();
        end

        // Saturating counter instance (CNT_W=2).
        for (int i = 0; i < 3; i++) begin
            bus2.speed = 12'd100; bus2.speed_valid = 1'b1; tick();
            bus2.speed_valid = 1'b0; tick(20);
        end
        bus2.speed = 12'd4000; bus2.speed_valid = 1'b1; tick();
        bus2.speed_valid = 1'b0;
        @(negedge clk);
        chk("sat no divide", bus2.busy, 0);
        tick(20);
        chk("sat avg", bus2.avg, 100);
        chk("sat cur_speed", bus2.cur_speed, 4000);
        chk("sat avg_valid count", av2_cnt, 3);
        bus2.mode_btn = 1'b1; tick();
        bus2.mode_btn = 1'b0; tick();
        @(negedge clk);
        chk("sat disp_mode", bus2.disp_mode, 1);
        chk("sat disp_val", bus2.disp_val, 4000);
        tick();

        // Randomized soak against the model.
        for (int i = 0; i < 3000; i++) begin
            bus.speed_valid = ($urandom_range(0, 7) == 0);
            bus.speed       = W'($urandom_range(0, SPD_MAX));
            bus.mode_btn    = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 39) == 0) bus.clr_btn = !bus.clr_btn;
            r = ($urandom_range(0, 799) == 0);
            tick();
        end
        r = 1'b0; bus.speed_valid = 1'b0; bus.mode_btn = 1'b0; bus.clr_btn = 1'b0;
        tick(40);
        chk("scoreboard drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
